// File: rtl/lcd_cmd_sequencer_pkg.sv
// lcd_pkg: shared definitions for the LCD command sequencer.
//   CMD_W            opcode width
//   CMD_WRITE ..     opcode values understood by the LCD image controller
//   CMD_MIRROR_Y
//   state_t          sequencer FSM state encoding
//   is_droppable()   true for opcodes outside the controller's defined set (12-15)
package lcd_pkg;

  localparam int CMD_W = 4;

  localparam logic [CMD_W-1:0] CMD_WRITE       = 4'd0;
  localparam logic [CMD_W-1:0] CMD_SHIFT_UP    = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SHIFT_DOWN  = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHIFT_LEFT  = 4'd3;
  localparam logic [CMD_W-1:0] CMD_SHIFT_RIGHT = 4'd4;
  localparam logic [CMD_W-1:0] CMD_MAX         = 4'd5;
  localparam logic [CMD_W-1:0] CMD_MIN         = 4'd6;
  localparam logic [CMD_W-1:0] CMD_AVG         = 4'd7;
  localparam logic [CMD_W-1:0] CMD_ROTATE_CCW  = 4'd8;
  localparam logic [CMD_W-1:0] CMD_ROTATE_CW   = 4'd9;
  localparam logic [CMD_W-1:0] CMD_MIRROR_X    = 4'd10;
  localparam logic [CMD_W-1:0] CMD_MIRROR_Y    = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_GUARD     = 3'd2,
    ST_WAIT      = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  function automatic logic is_droppable(input logic [CMD_W-1:0] op);
    return (op > CMD_MIRROR_Y);
  endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_fifo.sv
// lcd_cmd_fifo: DEPTH x W synchronous FIFO with show-ahead read.
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset (empties the FIFO)
//   push   in   write din (ignored when full)
//   pop    in   discard head (ignored when empty)
//   din    in   W-bit write data
//   dout   out  current head entry, valid while !empty
//   full   out  DEPTH entries held
//   empty  out  no entries held
//   count  out  occupancy, 0..DEPTH
// The head is read combinationally so the consumer can capture it on the
// same edge that pops it.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_en;
  logic          w_pop_en;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_push_en = push && !full;
  assign w_pop_en  = pop && !empty;

  // Storage is not reset; emptiness is tracked purely by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: buffers host opcodes and issues them one at a time to
// the LCD image controller, halting for good once a Write has completed.
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   in_valid       in   host offers in_cmd
//   in_cmd         in   opcode (0 Write, 1-11 image operations)
//   in_ready       out  FIFO accepts; transfer on in_valid && in_ready
//   lcd_cmd        out  last issued opcode (registered)
//   lcd_cmd_valid  out  one-cycle issue strobe (registered)
//   lcd_busy       in   controller busy (image load or execution)
//   lcd_done       in   controller finished the Write
//   seq_done       out  sticky: Write completed, sequencer halted
//   fifo_count     out  FIFO occupancy
//   issued_cnt     out  saturating count of issued commands
//   drop_cnt       out  saturating count of discarded opcodes 12-15
//                       (only when LCD_SEQ_FILTER_EN is defined)
// Build option LCD_SEQ_FILTER_EN: when defined, head opcodes 12-15 are popped
// and discarded in IDLE instead of being issued.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [CMD_W-1:0]        in_cmd,
  output logic                    in_ready,
  output logic [CMD_W-1:0]        lcd_cmd,
  output logic                    lcd_cmd_valid,
  input  logic                    lcd_busy,
  input  logic                    lcd_done,
  output logic                    seq_done,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [CNT_W-1:0]        issued_cnt
`ifdef LCD_SEQ_FILTER_EN
  ,
  output logic [CNT_W-1:0]        drop_cnt
`endif
);

  state_t             r_state;
  state_t             w_state_next;
  logic [CMD_W-1:0]   r_lcd_cmd;
  logic               r_lcd_cmd_valid;
  logic               r_seq_done;
  logic [CNT_W-1:0]   r_issued_cnt;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_issue;
  logic [CMD_W-1:0]   w_head;
`ifdef LCD_SEQ_FILTER_EN
  logic               w_drop;
  logic [CNT_W-1:0]   r_drop_cnt;
`endif

  assign in_ready      = !w_full && !r_seq_done;
  assign w_push        = in_valid && in_ready;
  assign lcd_cmd       = r_lcd_cmd;
  assign lcd_cmd_valid = r_lcd_cmd_valid;
  assign seq_done      = r_seq_done;
  assign issued_cnt    = r_issued_cnt;

  lcd_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (in_cmd),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_issue      = 1'b0;
`ifdef LCD_SEQ_FILTER_EN
    w_drop       = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !r_seq_done) begin
`ifdef LCD_SEQ_FILTER_EN
          // Undefined opcodes never reach the controller, busy or not.
          if (is_droppable(w_head)) begin
            w_pop  = 1'b1;
            w_drop = 1'b1;
          end else
`endif
          if (!lcd_busy) begin
            w_pop        = 1'b1;
            w_issue      = 1'b1;
            w_state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        w_state_next = ST_GUARD;
      end
      // The controller raises busy only on the edge after it accepts the
      // strobe, so busy is not trusted until one cycle later.
      ST_GUARD: begin
        w_state_next = (r_lcd_cmd == CMD_WRITE) ? ST_WAIT_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (!lcd_busy) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (lcd_done) begin
          w_state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lcd_cmd       <= '0;
      r_lcd_cmd_valid <= 1'b0;
      r_seq_done      <= 1'b0;
      r_issued_cnt    <= '0;
    end else begin
      r_lcd_cmd_valid <= w_issue;
      if (w_issue) begin
        r_lcd_cmd <= w_head;
      end
      if ((r_state == ST_ISSUE) && (r_issued_cnt != '1)) begin
        r_issued_cnt <= r_issued_cnt + CNT_W'(1);
      end
      if ((r_state == ST_WAIT_DONE) && lcd_done) begin
        r_seq_done <= 1'b1;
      end
    end
  end

`ifdef LCD_SEQ_FILTER_EN
  assign drop_cnt = r_drop_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
module tb_lcd_cmd_sequencer;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int WRITE_T = 66;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic [3:0]             in_cmd;
  logic                   in_ready;
  logic [3:0]             lcd_cmd;
  logic                   lcd_cmd_valid;
  logic                   lcd_busy;
  logic                   lcd_done;
  logic                   seq_done;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0]       issued_cnt;
`ifdef LCD_SEQ_FILTER_EN
  logic [CNT_W-1:0]       drop_cnt;
`endif

  lcd_cmd_sequencer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_cmd        (in_cmd),
    .in_ready      (in_ready),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .lcd_busy      (lcd_busy),
    .lcd_done      (lcd_done),
    .seq_done      (seq_done),
    .fifo_count    (fifo_count),
    .issued_cnt    (issued_cnt)
`ifdef LCD_SEQ_FILTER_EN
    ,
    .drop_cnt      (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and controller model state
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_q[$];      // accepted but not yet issued, in host order
  int strobe_q[$];   // opcodes seen on the strobe, this test
  int strobe_cyc[$]; // cycle of each strobe, this test
  int n_iss;
  int exp_drops;
  int last_op;
  int busy_left;
  int done_left;
  int done_cyc;
  int seq_cyc;
  int exec_len;
  bit rand_exec;
  bit force_busy;
  bit accept_pending;
  bit write_issued;
  bit chk_occ;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sat(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic clear_model();
    acc_q.delete();
    strobe_q.delete();
    strobe_cyc.delete();
    n_iss = 0; exp_drops = 0; last_op = 0;
    busy_left = 0; done_left = 0; done_cyc = -1; seq_cyc = -1;
    accept_pending = 0; write_issued = 0; chk_occ = 0;
    rand_exec = 0; exec_len = 1;
    lcd_done = 1'b0;
    lcd_busy = force_busy;
  endtask

  // One clock: record the handshake, advance, then model the controller and
  // score any strobe against the host order.
  task automatic tick();
    if (in_valid && in_ready) acc_q.push_back(int'(in_cmd));
    @(posedge clk);
    #1;
    cyc++;
    lcd_done = 1'b0;
    if (accept_pending) begin
      accept_pending = 0;
      if (last_op == 0) begin
        busy_left = WRITE_T;
        done_left = WRITE_T;
      end else begin
        busy_left = rand_exec ? int'($urandom_range(1, 3)) : exec_len;
      end
    end else begin
      if (busy_left > 0) busy_left--;
      if (done_left > 0) begin
        done_left--;
        if (done_left == 0) begin
          lcd_done = 1'b1;
          done_cyc = cyc;
        end
      end
    end
    lcd_busy = force_busy || (busy_left > 0);
    if (seq_done && seq_cyc < 0) seq_cyc = cyc;
    if (chk_occ) check_val("issued_cnt", int'(issued_cnt), sat(n_iss));
    if (lcd_cmd_valid) begin
      $display("strobe op=%0d cycle=%0d", lcd_cmd, cyc);
      if (write_issued) check_val("strobe_after_write", 1, 0);
`ifdef LCD_SEQ_FILTER_EN
      while (acc_q.size() > 0 && acc_q[0] > 11) begin
        void'(acc_q.pop_front());
        exp_drops++;
      end
`endif
      if (acc_q.size() == 0) check_val("strobe_unexpected", int'(lcd_cmd), -1);
      else check_val("strobe_op", int'(lcd_cmd), acc_q.pop_front());
      strobe_q.push_back(int'(lcd_cmd));
      strobe_cyc.push_back(cyc);
      n_iss++;
      last_op = int'(lcd_cmd);
      accept_pending = 1;
      if (lcd_cmd == 4'd0) write_issued = 1;
    end
    if (chk_occ) begin
      check_val("fifo_count", int'(fifo_count), acc_q.size());
      check_val("in_ready", int'(in_ready), (acc_q.size() < DEPTH) ? 1 : 0);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check_val({pfx, "_in_ready"}, int'(in_ready), 1);
    check_val({pfx, "_lcd_cmd"}, int'(lcd_cmd), 0);
    check_val({pfx, "_valid"}, int'(lcd_cmd_valid), 0);
    check_val({pfx, "_seq_done"}, int'(seq_done), 0);
    check_val({pfx, "_fifo_count"}, int'(fifo_count), 0);
    check_val({pfx, "_issued_cnt"}, int'(issued_cnt), 0);
  endtask

  task automatic do_reset(input bit hold_busy);
    in_valid = 1'b0;
    in_cmd = 4'd0;
    force_busy = hold_busy;
    reset = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b0;
  endtask

  task automatic push_list(input int ops[$]);
    foreach (ops[i]) begin
      in_valid = 1'b1;
      in_cmd = ops[i][3:0];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int t = 0;
    while ((acc_q.size() != 0 || busy_left != 0 || accept_pending) && t < max_cyc) begin
      tick();
      t++;
    end
    if (t >= max_cyc) check_val("drain_timeout", 1, 0);
    repeat (6) tick();
  endtask

  initial begin
    int ops[$];
    int exp6[$];
    int t;
    int n0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_cmd = 4'd0;
    lcd_busy = 1'b1;
    lcd_done = 1'b0;
    force_busy = 1'b1;

    // 1: busy held after reset blocks every strobe
    do_reset(1'b1);
    ops = '{1, 2, 3};
    push_list(ops);
    repeat (61) tick();
    check_val("t1_no_strobe_while_busy", strobe_q.size(), 0);
    check_val("t1_fifo_count", int'(fifo_count), 3);
    force_busy = 1'b0;
    lcd_busy = 1'b0;
    t = 0;
    while (strobe_q.size() == 0 && t < 10) begin
      tick();
      t++;
    end
    check_val("t1_first_strobe_latency_ok", (t >= 1 && t <= 2) ? 1 : 0, 1);
    drain(200);
    check_val("t1_strobes", strobe_q.size(), 3);

    // 2: back-to-back issue with 1-cycle execution
    do_reset(1'b0);
    exec_len = 1;
    ops = '{1, 2, 3, 4};
    push_list(ops);
    drain(200);
    check_val("t2_strobes", strobe_q.size(), 4);
    for (int i = 1; i < strobe_cyc.size(); i++)
      check_val("t2_spacing", strobe_cyc[i] - strobe_cyc[i-1], 4);
    check_val("t2_issued_cnt", int'(issued_cnt), 4);

    // 3: overfill while busy, then drain
    do_reset(1'b1);
    ops.delete();
    for (int i = 0; i < DEPTH + 2; i++) ops.push_back(int'($urandom_range(1, 11)));
    push_list(ops);
    check_val("t3_accepted", acc_q.size(), DEPTH);
    check_val("t3_in_ready", int'(in_ready), 0);
    check_val("t3_fifo_count", int'(fifo_count), DEPTH);
    force_busy = 1'b0;
    lcd_busy = 1'b0;
    drain(400);
    check_val("t3_strobes", strobe_q.size(), DEPTH);
    check_val("t3_issued_cnt", int'(issued_cnt), DEPTH);

    // 4: Write halts the sequencer; later command never issued
    do_reset(1'b0);
    ops = '{5, 0, 7};
    push_list(ops);
    t = 0;
    while (seq_cyc < 0 && t < 300) begin
      tick();
      t++;
    end
    check_val("t4_seq_done_seen", (seq_cyc >= 0) ? 1 : 0, 1);
    check_val("t4_seq_done_latency", seq_cyc - done_cyc, 1);
    repeat (20) tick();
    in_valid = 1'b1;
    in_cmd = 4'd2;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check_val("t4_strobes", strobe_q.size(), 2);
    check_val("t4_in_ready", int'(in_ready), 0);
    check_val("t4_fifo_count", int'(fifo_count), 1);
    check_val("t4_lcd_cmd_hold", int'(lcd_cmd), 0);
    check_val("t4_seq_done", int'(seq_done), 1);

    // 5: asynchronous reset while waiting on a long command
    do_reset(1'b0);
    exec_len = 20;
    ops = '{1, 2, 3};
    push_list(ops);
    repeat (6) tick();
    check_val("t5_queued", int'(fifo_count), 2);
    check_val("t5_in_wait_busy", int'(lcd_busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("t5_async");
    force_busy = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (30) tick();
    check_val("t5_no_strobe", strobe_q.size(), 0);
    check_val("t5_fifo_count", int'(fifo_count), 0);
    check_val("t5_issued_cnt", int'(issued_cnt), 0);
    ops = '{6};
    push_list(ops);
    drain(100);
    check_val("t5_recovered", strobe_q.size(), 1);

    // 6: opcodes 12-15
    do_reset(1'b0);
    ops = '{3, 14, 12, 9};
    push_list(ops);
    drain(200);
`ifdef LCD_SEQ_FILTER_EN
    exp6 = '{3, 9};
    check_val("t6_drop_cnt", int'(drop_cnt), 2);
    check_val("t6_model_drops", exp_drops, 2);
`else
    exp6 = '{3, 14, 12, 9};
`endif
    check_val("t6_strobes", strobe_q.size(), exp6.size());
    for (int i = 0; i < strobe_q.size() && i < exp6.size(); i++)
      check_val("t6_order", strobe_q[i], exp6[i]);

    // 7: random traffic, random execution time, counter saturation
    do_reset(1'b0);
    rand_exec = 1;
    chk_occ = 1;
    t = 0;
    while (n_iss < CNT_MAX + 15 && t < 4000) begin
      in_valid = ($urandom_range(0, 99) < 60);
      in_cmd = 4'($urandom_range(1, 11));
      tick();
      t++;
    end
    in_valid = 1'b0;
    drain(200);
    n0 = n_iss;
    check_val("t7_enough_issued", (n0 > CNT_MAX) ? 1 : 0, 1);
    check_val("t7_issued_cnt_sat", int'(issued_cnt), sat(n0));
    check_val("t7_fifo_empty", int'(fifo_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
